// File: rtl/if_id_stage.sv
// Fetch PC register plus IF/ID pipeline register for the RV32I 5-stage pipeline.
// Latency: 1 cycle from PCF to InstrD; ImemAddr is a combinational copy of PCF.
// Backpressure: StallF holds PCF, StallD holds IF/ID; redirect beats StallF, flush beats StallD.
// Optional: FETCH_MISALIGN_CHECK_EN adds MisalignD and turns misaligned fetches into bubbles.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemRdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        MisalignD,
`endif
    output logic [31:0] FetchCount
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        valid;
        logic        misalign;
    } ifid_t;

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: 32'd0, pcplus4: 32'd0,
                                 valid: 1'b0, misalign: 1'b0};

    logic [31:0] pcplus4_f;
    logic [31:0] pc_next;
    logic        misalign_f;
    logic        load_d;
    ifid_t       ifid_q;
    ifid_t       ifid_next;

    assign pcplus4_f = PCF + 32'd4;
    assign ImemAddr  = PCF;
    assign load_d    = !FlushD && !StallD;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign_f = (PCF[1:0] != 2'b00);
    assign MisalignD  = ifid_q.misalign;
`else
    assign misalign_f = 1'b0;
`endif

    always_comb begin
        pc_next = pcplus4_f;
        if (PCSrcE)
            pc_next = PCTargetE;
        else if (StallF)
            pc_next = PCF;
    end

    always_comb begin
        ifid_next = ifid_q;
        if (FlushD) begin
            ifid_next = BUBBLE;
        end else if (!StallD) begin
            ifid_next.pc      = PCF;
            ifid_next.pcplus4 = pcplus4_f;
            if (misalign_f) begin
                // Keep the faulting PC visible so decode can report it.
                ifid_next.instr    = NOP_INSTR;
                ifid_next.valid    = 1'b0;
                ifid_next.misalign = 1'b1;
            end else begin
                ifid_next.instr    = ImemRdata;
                ifid_next.valid    = 1'b1;
                ifid_next.misalign = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PCF        <= RESET_PC;
            ifid_q     <= BUBBLE;
            FetchCount <= 32'd0;
        end else begin
            PCF    <= pc_next;
            ifid_q <= ifid_next;
            if (load_d && !misalign_f)
                FetchCount <= FetchCount + 32'd1;
        end
    end

    assign InstrD   = ifid_q.instr;
    assign PCD      = ifid_q.pc;
    assign PCPlus4D = ifid_q.pcplus4;
    assign ValidD   = ifid_q.valid;

endmodule
